// File: rtl/pb_capture_slave_if.sv
`default_nettype none
// ==========================================================================
// pb_capture_slave_if: Avalon-MM register bus and interrupt for pb_capture_slave
// Rev 1.0
// ==========================================================================
interface pb_capture_slave_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/pb_capture_slave.sv
`default_nettype none
// ==========================================================================
// pb_capture_slave: debounced pushbutton capture with press counts and irq
// Rev 1.0
// ==========================================================================
module pb_capture_slave #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic [NUM_BUTTONS-1:0] buttons,
  pb_capture_slave_if.slave           bus
);

  localparam int                 c_cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] r_s1;
  logic [NUM_BUTTONS-1:0] r_s2;
  logic [NUM_BUTTONS-1:0] r_edge;
  logic [NUM_BUTTONS-1:0] r_mask;
  logic [31:0]            r_readdata;

  logic [NUM_BUTTONS-1:0] w_db;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_edge_clr;
  logic                   w_cnt_clr;
  logic [7:0]             w_count [NUM_BUTTONS];
  logic [31:0]            w_count_word;
  logic [31:0]            w_rd;
  logic                   w_unused_wdata;

  assign w_edge_clr = (bus.write && bus.address == 2'd1) ? bus.writedata[NUM_BUTTONS-1:0] : '0;
  assign w_cnt_clr  = bus.write && bus.address == 2'd3;
  assign w_unused_wdata = ^{1'b0, bus.writedata[31:NUM_BUTTONS]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= buttons;
      r_s2 <= r_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_db;
      logic [7:0]         r_count;

      // Any cycle where the synchronized level agrees with db restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_s2[gi] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_last) begin
          r_cnt <= '0;
          r_db  <= r_s2[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_press[gi] = r_s2[gi] & ~r_db & (r_cnt == c_last);
      assign w_db[gi]    = r_db;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_count <= '0;
        end else if (w_cnt_clr) begin
          r_count <= {7'd0, w_press[gi]};
        end else if (w_press[gi]) begin
          r_count <= r_count + 8'd1;
        end
      end

      assign w_count[gi] = r_count;
    end
  endgenerate

  // A press on the same edge as a write-1-to-clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge <= '0;
      r_mask <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_press;
      if (bus.write && bus.address == 2'd2) begin
        r_mask <= bus.writedata[NUM_BUTTONS-1:0];
      end
    end
  end

  always_comb begin
    w_count_word = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_count_word[8*i +: 8] = w_count[i];
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      2'd0:    w_rd[NUM_BUTTONS-1:0] = w_db;
      2'd1:    w_rd[NUM_BUTTONS-1:0] = r_edge;
      2'd2:    w_rd[NUM_BUTTONS-1:0] = r_mask;
      default: w_rd = w_count_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (bus.read) begin
      r_readdata <= w_rd;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_pb_capture_slave.sv
`default_nettype none
// ==========================================================================
// tb_pb_capture_slave: directed self-checking bench for pb_capture_slave
// Rev 1.0
// ==========================================================================
module tb_pb_capture_slave;

  logic       clk;
  logic       reset;
  logic [2:0] btn;
  int         n_checks;
  int         n_errors;
  logic [31:0] rd;
  logic [14:0] bounce;

  pb_capture_slave_if bus_if ();

  pb_capture_slave #(
    .NUM_BUTTONS     (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .buttons (btn),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address   = a;
    bus_if.writedata = d;
    bus_if.write     = 1'b1;
    tick();
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    bus_if.read    = 1'b1;
    tick();
    bus_if.read    = 1'b0;
    d = bus_if.readdata;
  endtask

  task automatic check_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic press_release(input logic [2:0] b);
    btn = b;
    ticks(7);
    btn = 3'b000;
    ticks(7);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    btn = 3'b000;
    bus_if.address = 2'd0;
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.writedata = '0;
    bounce = 15'b111011100000000;

    // Reset values
    ticks(3);
    reset = 1'b0;
    check("rst_readdata", bus_if.readdata, 32'h0);
    check("rst_irq", {31'd0, bus_if.irq}, 32'h0);
    check_read("rst_data", 2'd0, 32'h0);
    check_read("rst_edge", 2'd1, 32'h0);
    check_read("rst_mask", 2'd2, 32'h0);
    check_read("rst_count", 2'd3, 32'h0);

    // Clean press: s1 samples at edge k, db updates at k+5
    btn = 3'b001;
    ticks(5);
    check_read("press_data_k5_pre", 2'd0, 32'h0);
    check_read("press_data_after", 2'd0, 32'h1);
    check_read("press_edge", 2'd1, 32'h1);
    check_read("press_count", 2'd3, 32'h0000_0001);
    btn = 3'b000;
    ticks(8);
    check_read("release_data", 2'd0, 32'h0);
    check_read("release_edge_kept", 2'd1, 32'h1);
    bus_write(2'd1, 32'h1);
    bus_write(2'd3, 32'h0);
    check_read("edge_cleared", 2'd1, 32'h0);
    check_read("count_cleared", 2'd3, 32'h0);

    // Simultaneous read and write returns the pre-write value
    bus_if.address   = 2'd2;
    bus_if.writedata = 32'hFFFF_FFFB;
    bus_if.read      = 1'b1;
    bus_if.write     = 1'b1;
    tick();
    bus_if.read  = 1'b0;
    bus_if.write = 1'b0;
    check("rw_prewrite", bus_if.readdata, 32'h0);
    check_read("rw_mask_written", 2'd2, 32'h3);
    bus_write(2'd2, 32'h0);

    // Bounce rejection on button 1
    for (int i = 0; i < 15; i++) begin
      btn[1] = bounce[14-i];
      bus_read(2'd0, rd);
      check("bounce_data", rd, 32'h0);
    end
    check_read("bounce_edge", 2'd1, 32'h0);
    check_read("bounce_count", 2'd3, 32'h0);

    // Interrupt and clear
    bus_write(2'd2, 32'h4);
    check_read("mask_4", 2'd2, 32'h4);
    check("irq_idle", {31'd0, bus_if.irq}, 32'h0);
    btn = 3'b100;
    ticks(5);
    check("irq_before_event", {31'd0, bus_if.irq}, 32'h0);
    tick();
    check("irq_on_event", {31'd0, bus_if.irq}, 32'h1);
    btn = 3'b000;
    ticks(8);
    check("irq_held", {31'd0, bus_if.irq}, 32'h1);
    bus_write(2'd1, 32'h4);
    check("irq_after_clear", {31'd0, bus_if.irq}, 32'h0);
    btn = 3'b001;
    ticks(8);
    check("irq_masked_press", {31'd0, bus_if.irq}, 32'h0);
    check_read("masked_press_edge", 2'd1, 32'h1);
    btn = 3'b000;
    ticks(8);
    bus_write(2'd2, 32'h5);
    check("irq_mask_enable", {31'd0, bus_if.irq}, 32'h1);
    bus_write(2'd2, 32'h4);
    check("irq_mask_disable", {31'd0, bus_if.irq}, 32'h0);
    bus_write(2'd1, 32'h1);
    check_read("irq_counts", 2'd3, 32'h0001_0001);
    bus_write(2'd2, 32'h0);

    // Set wins over clear on the event edge
    btn = 3'b001;
    ticks(5);
    bus_write(2'd1, 32'h1);
    check_read("setclr_edge", 2'd1, 32'h1);
    check_read("setclr_count", 2'd3, 32'h0001_0002);
    btn = 3'b000;
    ticks(8);
    bus_write(2'd1, 32'h1);
    btn = 3'b001;
    ticks(5);
    bus_write(2'd3, 32'h0);
    check_read("cntclr_event_count", 2'd3, 32'h0000_0001);
    check_read("cntclr_event_edge", 2'd1, 32'h1);
    btn = 3'b000;
    ticks(8);

    // Writes to DATA are ignored
    bus_write(2'd0, 32'hFFFF_FFFF);
    check_read("data_write_ignored", 2'd0, 32'h0);
    check_read("data_write_mask", 2'd2, 32'h0);

    // Count wrap on button 1
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h7);
    for (int i = 0; i < 255; i++) press_release(3'b010);
    check_read("count_255", 2'd3, 32'h0000_FF00);
    press_release(3'b010);
    check_read("count_wrap", 2'd3, 32'h0000_0000);
    check_read("wrap_edge", 2'd1, 32'h2);

    // Reset during a partial debounce
    bus_write(2'd2, 32'h7);
    check("pre_reset_irq", {31'd0, bus_if.irq}, 32'h1);
    check_read("pre_reset_mask", 2'd2, 32'h7);
    btn = 3'b001;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_readdata", bus_if.readdata, 32'h0);
    check("midrst_irq", {31'd0, bus_if.irq}, 32'h0);
    check_read("midrst_data", 2'd0, 32'h0);
    check_read("midrst_edge", 2'd1, 32'h0);
    check_read("midrst_mask", 2'd2, 32'h0);
    check_read("midrst_count", 2'd3, 32'h0);
    check_read("midrst_data_r5", 2'd0, 32'h0);
    check_read("midrst_data_r6_pre", 2'd0, 32'h0);
    check_read("midrst_data_after", 2'd0, 32'h1);
    check_read("midrst_count_after", 2'd3, 32'h0000_0001);
    check_read("midrst_edge_after", 2'd1, 32'h1);
    check("midrst_irq_after", {31'd0, bus_if.irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
